// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: datapath width, fetch FSM states and default PC increment.
package rv_pipe_pkg;

   localparam int XLEN            = 32;
   localparam int PC_STEP_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      HOLD,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundles the redirect, instruction-memory and IF/ID handshake signals of the fetch unit.
interface pc_fetch_unit_if;
   import rv_pipe_pkg::*;

   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            if_stall;
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;

   modport master (
      input  redirect, redirect_pc, imem_rvalid, imem_rdata, if_stall,
      output imem_req, imem_addr, if_valid, if_instr, if_pc
   );

   modport slave (
      output redirect, redirect_pc, imem_rvalid, imem_rdata, if_stall,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc
   );

endinterface

// File: rtl/mux_2x1.sv
// Generic 2:1 multiplexer; sel=1 picks data_in1, sel=0 picks data_in2.
module mux_2x1 #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] data_in1,
   input  logic [WIDTH-1:0] data_in2,
   output logic [WIDTH-1:0] data_out
);

   assign data_out = sel ? data_in1 : data_in2;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem fetch, IF/ID output with 1-entry hold buffer.
// Optional FETCH_CNT_EN adds a consume counter on output fetch_cnt.
module pc_fetch_unit
   import rv_pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   pc_fetch_unit_if.master    bus
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]        fetch_cnt
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pcSeq, pcNext;
   logic            outValid_q, outValid_d;
   logic [XLEN-1:0] outInstr_q, outInstr_d;
   logic [XLEN-1:0] outPc_q, outPc_d;
   logic            holdValid_q, holdValid_d;
   logic [XLEN-1:0] holdInstr_q, holdInstr_d;
   logic [XLEN-1:0] holdPc_q, holdPc_d;
   logic            consume;
   logic            outFree;

   assign consume = outValid_q & ~bus.if_stall;
   assign outFree = ~outValid_q | consume;
   assign pcSeq   = pc_q + XLEN'(PC_STEP);

   mux_2x1 #(.WIDTH(XLEN)) uNextPc (
      .sel      (bus.redirect),
      .data_in1 (bus.redirect_pc),
      .data_in2 (pcSeq),
      .data_out (pcNext)
   );

   // Normal progress first; a redirect then overrides pc, flushes both output and buffer, and picks the exit state.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      outValid_d  = outValid_q & ~consume;
      outInstr_d  = outInstr_q;
      outPc_d     = outPc_q;
      holdValid_d = holdValid_q;
      holdInstr_d = holdInstr_q;
      holdPc_d    = holdPc_q;

      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: state_d = WAIT;
         WAIT: begin
            if (bus.imem_rvalid) begin
               pc_d = pcNext;
               if (outFree) begin
                  outValid_d = 1'b1;
                  outInstr_d = bus.imem_rdata;
                  outPc_d    = pc_q;
                  state_d    = FETCH;
               end else begin
                  holdValid_d = 1'b1;
                  holdInstr_d = bus.imem_rdata;
                  holdPc_d    = pc_q;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (consume && holdValid_q) begin
               outValid_d  = 1'b1;
               outInstr_d  = holdInstr_q;
               outPc_d     = holdPc_q;
               holdValid_d = 1'b0;
               state_d     = FETCH;
            end
         end
         DRAIN: begin
            if (bus.imem_rvalid) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase

      if (bus.redirect) begin
         pc_d        = pcNext;
         outValid_d  = 1'b0;
         holdValid_d = 1'b0;
         case (state_q)
            FETCH:       state_d = DRAIN;
            WAIT, DRAIN: state_d = bus.imem_rvalid ? FETCH : DRAIN;
            default:     state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         outValid_q  <= 1'b0;
         outInstr_q  <= '0;
         outPc_q     <= '0;
         holdValid_q <= 1'b0;
         holdInstr_q <= '0;
         holdPc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         outValid_q  <= outValid_d;
         outInstr_q  <= outInstr_d;
         outPc_q     <= outPc_d;
         holdValid_q <= holdValid_d;
         holdInstr_q <= holdInstr_d;
         holdPc_q    <= holdPc_d;
      end
   end

   // Request strobe and address come purely from registered state so imem sees no input-to-output path.
   assign bus.imem_req  = (state_q == FETCH);
   assign bus.imem_addr = (state_q == FETCH) ? pc_q : '0;
   assign bus.if_valid  = outValid_q;
   assign bus.if_instr  = outInstr_q;
   assign bus.if_pc     = outPc_q;

`ifdef FETCH_CNT_EN
   logic [31:0] fetchCnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetchCnt_q <= '0;
      end else if (consume) begin
         fetchCnt_q <= fetchCnt_q + 32'd1;
      end
   end

   assign fetch_cnt = fetchCnt_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end of the pipelined core. Holds the program counter, issues one instruction-memory request at a time, and registers each returned instruction with its PC into the IF/ID boundary under a valid/stall handshake. Branch or jump redirects from EX overwrite the PC and flush fetched instructions that are in flight or not yet consumed. The next-PC value is chosen between the redirect target and the sequential PC by the 2:1 next-PC select feeding the PC register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports (clock and reset first):
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  single-cycle pulse from EX: take redirect_pc.
- redirect_pc  in  32  branch/jump target.
- imem_req  out  1  fetch request strobe, one cycle per request.
- imem_addr  out  32  fetch address; valid only while imem_req=1.
- imem_rvalid  in  1  response strobe, at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- if_stall  in  1  IF/ID cannot accept this cycle.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.

## Operation
- States:
  - IDLE: reset state. Always moves to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Moves to DRAIN if redirect, else to WAIT.
  - WAIT: waits for imem_rvalid.
  - HOLD: a response is parked in the 1-entry buffer.
  - DRAIN: waits for one stale response and discards it.
- Consume: a cycle with if_valid=1 and if_stall=0. After a consume, if_valid drops unless new data loads in the same cycle.
- WAIT, on imem_rvalid:
  - redirect in the same cycle: discard the response, pc<=redirect_pc, go to FETCH.
  - output register free (if_valid=0 or consume this cycle): load if_instr/if_pc, set if_valid=1, pc<=pc+PC_STEP, go to FETCH.
  - otherwise: park the response in the buffer, pc<=pc+PC_STEP, go to HOLD.
- HOLD: on consume, the buffer moves to the output register and the state goes to FETCH.
- Redirect (any state):
  - pc<=redirect_pc.
  - if_valid<=0 and the HOLD buffer is invalidated.
  - Redirect has priority over stall and over a same-cycle capture.
  - Redirect in WAIT without rvalid goes to DRAIN.
  - Redirect in HOLD or IDLE goes to FETCH.
- DRAIN: on imem_rvalid, discard and go to FETCH. A second redirect in DRAIN only updates pc.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- imem_rvalid outside WAIT/DRAIN is ignored.

## Timing
- Reset values:
  - imem_req=0, imem_addr=0.
  - if_valid=0, if_instr=0, if_pc=0.
  - pc=RESET_PC, state IDLE.
- First request goes out in the second rising edge's cycle after rst deasserts (IDLE, then FETCH).
- imem_req and imem_addr decode from registered state and pc; they have no combinational path from inputs.
- Latency: request in cycle N, response in cycle N+k (k≥1), if_valid=1 in cycle N+k+1. The next request is also in N+k+1.
- Peak throughput with k=1 is one instruction every 2 cycles.
- The outputs if_* are registered and stable while if_valid=1 and if_stall=1.
- Reset asserted mid-operation: all state returns to reset values immediately, and any outstanding response is ignored.

## Configuration
- FETCH_CNT_EN defined: adds output fetch_cnt, 32 bits.
  - Increments on every consume.
  - Reset value 0; wraps modulo 2^32.
  - Not affected by redirect.
- FETCH_CNT_EN undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package rv_pipe_pkg:
  - XLEN=32.
  - Fetch state enum: IDLE, FETCH, WAIT, HOLD, DRAIN.
  - Default PC_STEP constant.
- Sub-module: instantiate mux_2x1 for next-PC select, with sel=redirect, data_in1=redirect_pc, data_in2=pc+PC_STEP.
- The hold buffer is inline; it is one register pair plus a valid bit.

## Test plan
- Reset then k=1 memory: imem_addr sequence 0x0, 0x4, 0x8. if_pc 0x0/0x4/0x8 appear with one idle cycle between each; if_valid is never high for two consecutive new PCs.
- if_stall held for 5 cycles with if_pc=0x4 valid: response for 0x8 parks in HOLD, no new imem_req is issued, if_pc stays 0x4. On release, 0x8 appears next cycle and a request for 0xC follows.
- Redirect to 0x100 in WAIT, response arriving 3 cycles later: DRAIN discards it, the next imem_addr is 0x100, and nothing from the old path reaches if_valid.
- Redirect to 0x200 in the same cycle as imem_rvalid while output is stalled: response discarded, if_valid=0 next cycle, next request at 0x200.
- RESET_PC=32'hFFFF_FFFC: second fetch address wraps to 0x0.
- FETCH_CNT_EN build: 3 consumes, a redirect, then 2 consumes gives fetch_cnt=5. Async rst mid-WAIT sets fetch_cnt=0 and if_valid=0 immediately.
